regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with a per-register busy scoreboard.
// Register 0 is hard-wired to zero and is never marked busy. Reads are
// registered (one cycle latency) with write-through bypass from the same
// cycle's writes. Stall freezes only the read outputs; writes and scoreboard
// updates keep flowing.
// Legal parameter ranges: NREG a power of two and at least 2, NRD 1..4, NWR 1..4.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                stall,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr
);

  logic [XLEN-1:0]     regs_q [NREG];
  logic [XLEN-1:0]     regs_d [NREG];
  logic [NREG-1:0]     busy_q;
  logic [NREG-1:0]     busy_d;
  logic [NREG-1:0]     busyAfterClr;
  logic [NRD*XLEN-1:0] rd_data_q;
  logic [NRD*XLEN-1:0] rd_data_d;
  logic [NRD-1:0]      rd_busy_q;
  logic [NRD-1:0]      rd_busy_d;

  // Next register contents: ports applied in ascending order so the highest-index port wins a collision; address 0 is never stored.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      end
    end
  end

  // Scoreboard: writes clear first, then an alloc sets, so a new producer outlives a same-cycle write.
  always_comb begin
    busyAfterClr = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) begin
        busyAfterClr[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    busy_d = busyAfterClr;
    if (alloc_en && (alloc_addr != '0)) begin
      busy_d[alloc_addr] = 1'b1;
    end
  end

  // Read ports sample the post-write view (giving bypass for free) and the post-clear, pre-set busy view; hold when disabled or stalled.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    if (!stall) begin
      for (int i = 0; i < NRD; i++) begin
        if (rd_en[i]) begin
          if (rd_addr[i*AW +: AW] == '0) begin
            rd_data_d[i*XLEN +: XLEN] = '0;
            rd_busy_d[i]              = 1'b0;
          end else begin
            rd_data_d[i*XLEN +: XLEN] = regs_d[rd_addr[i*AW +: AW]];
            rd_busy_d[i]              = busyAfterClr[rd_addr[i*AW +: AW]];
          end
        end
      end
    end
  end

  // State update with synchronous reset taking priority over stall, writes and alloc.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q    <= '{default: '0};
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed vectors push expected read results into
// a scoreboard queue tagged with the clock edge that should produce them; an
// independent monitor pops and compares just after each rising edge.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                clk;
  logic                reset;
  logic [NRD-1:0]      rdEn;
  logic [NRD*AW-1:0]   rdAddr;
  logic [NRD*XLEN-1:0] rdData;
  logic [NRD-1:0]      rdBusy;
  logic                stall;
  logic [NWR-1:0]      wrEn;
  logic [NWR*AW-1:0]   wrAddr;
  logic [NWR*XLEN-1:0] wrData;
  logic                allocEn;
  logic [AW-1:0]       allocAddr;

  typedef struct {
    int              cyc;
    int              port;
    logic [XLEN-1:0] data;
    logic            busy;
    string           name;
  } expT;

  expT sb[$];
  int  cycCount   = 0;
  int  checkCount = 0;
  int  errorCount = 0;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rdEn),
    .rd_addr    (rdAddr),
    .rd_data    (rdData),
    .rd_busy    (rdBusy),
    .stall      (stall),
    .wr_en      (wrEn),
    .wr_addr    (wrAddr),
    .wr_data    (wrData),
    .alloc_en   (allocEn),
    .alloc_addr (allocAddr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clearInputs();
    reset     = 1'b0;
    rdEn      = '0;
    rdAddr    = '0;
    stall     = 1'b0;
    wrEn      = '0;
    wrAddr    = '0;
    wrData    = '0;
    allocEn   = 1'b0;
    allocAddr = '0;
  endtask

  task automatic doWrite(input int port, input int addr, input logic [XLEN-1:0] data);
    wrEn[port]               = 1'b1;
    wrAddr[port*AW +: AW]    = AW'(addr);
    wrData[port*XLEN +: XLEN] = data;
  endtask

  task automatic doRead(input int port, input int addr);
    rdEn[port]            = 1'b1;
    rdAddr[port*AW +: AW] = AW'(addr);
  endtask

  task automatic doAlloc(input int addr);
    allocEn   = 1'b1;
    allocAddr = AW'(addr);
  endtask

  // Expectation for the outputs produced by the upcoming rising edge.
  task automatic expectRead(input int port, input logic [XLEN-1:0] data, input logic busy, input string name);
    expT e;
    e.cyc  = cycCount + 1;
    e.port = port;
    e.data = data;
    e.busy = busy;
    e.name = name;
    sb.push_back(e);
  endtask

  // Let one rising edge consume the current inputs, then return at the falling edge with inputs cleared.
  task automatic applyStimulus();
    @(posedge clk);
    @(negedge clk);
    clearInputs();
  endtask

  task automatic checkOutput(input expT e);
    logic [XLEN-1:0] gotData;
    logic            gotBusy;
    gotData = rdData[e.port*XLEN +: XLEN];
    gotBusy = rdBusy[e.port];
    checkCount++;
    if (gotData !== e.data || gotBusy !== e.busy) begin
      errorCount++;
      $display("[TB] FAIL %s port%0d: got data=0x%08h busy=%b, expected data=0x%08h busy=%b",
               e.name, e.port, gotData, gotBusy, e.data, e.busy);
    end
  endtask

  // Monitor: shortly after every rising edge, compare all expectations due at that edge.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      cycCount++;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cycCount) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    clearInputs();

    // Reset from power-up
    reset = 1'b1;
    expectRead(0, 32'h0, 1'b0, "reset_state");
    expectRead(1, 32'h0, 1'b0, "reset_state");
    applyStimulus();

    // Write x5 then read it back on port 1
    doWrite(0, 5, 32'hDEADBEEF);
    applyStimulus();
    doRead(1, 5);
    expectRead(1, 32'hDEADBEEF, 1'b0, "read_x5");
    applyStimulus();

    // Same-address write collision with bypass: port 1 wins
    doWrite(0, 7, 32'h11);
    doWrite(1, 7, 32'h22);
    doRead(0, 7);
    expectRead(0, 32'h22, 1'b0, "bypass_collision_x7");
    applyStimulus();
    doRead(0, 7);
    expectRead(0, 32'h22, 1'b0, "stored_x7");
    applyStimulus();

    // Plain bypass from port 0 onto read port 1
    doWrite(0, 9, 32'hA5A5_0F0F);
    doRead(1, 9);
    expectRead(1, 32'hA5A5_0F0F, 1'b0, "bypass_x9");
    applyStimulus();

    // x0 ignores writes and allocs, including the same-cycle read
    doWrite(0, 0, 32'hFFFFFFFF);
    doAlloc(0);
    doRead(0, 0);
    expectRead(0, 32'h0, 1'b0, "x0_same_cycle");
    applyStimulus();
    doRead(0, 0);
    doRead(1, 0);
    expectRead(0, 32'h0, 1'b0, "x0_read");
    expectRead(1, 32'h0, 1'b0, "x0_read");
    applyStimulus();

    // Scoreboard: alloc, observe busy, write clears, alloc+write keeps busy
    doAlloc(3);
    applyStimulus();
    doRead(0, 3);
    expectRead(0, 32'h0, 1'b1, "busy_x3");
    applyStimulus();
    doWrite(1, 3, 32'h5);
    doRead(0, 3);
    expectRead(0, 32'h5, 1'b0, "write_clears_x3");
    applyStimulus();
    doAlloc(3);
    doWrite(0, 3, 32'h6);
    doRead(0, 3);
    expectRead(0, 32'h6, 1'b0, "alloc_write_same_read");
    applyStimulus();
    doRead(1, 3);
    expectRead(1, 32'h6, 1'b1, "alloc_wins_x3");
    applyStimulus();

    // Stall freezes outputs while writes and scoreboard updates continue
    doRead(0, 5);
    doRead(1, 3);
    expectRead(0, 32'hDEADBEEF, 1'b0, "pre_stall_x5");
    expectRead(1, 32'h6, 1'b1, "pre_stall_x3");
    applyStimulus();
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1;
      doRead(0, 7);
      doRead(1, 7);
      doWrite(0, 5, 32'h1);
      if (k == 1) doWrite(1, 3, 32'h9);
      expectRead(0, 32'hDEADBEEF, 1'b0, "stall_hold");
      expectRead(1, 32'h6, 1'b1, "stall_hold");
      applyStimulus();
    end
    doRead(0, 5);
    doRead(1, 3);
    expectRead(0, 32'h1, 1'b0, "post_stall_x5");
    expectRead(1, 32'h9, 1'b0, "post_stall_x3");
    applyStimulus();

    // rd_en low holds previous outputs even while registers change
    doWrite(0, 5, 32'h2);
    doAlloc(3);
    expectRead(0, 32'h1, 1'b0, "hold_rden_low");
    expectRead(1, 32'h9, 1'b0, "hold_rden_low");
    applyStimulus();

    // Mid-traffic reset with alloc, write and stall asserted
    doAlloc(10);
    applyStimulus();
    reset = 1'b1;
    stall = 1'b1;
    doAlloc(11);
    doWrite(0, 12, 32'h55);
    doRead(0, 5);
    expectRead(0, 32'h0, 1'b0, "mid_reset");
    expectRead(1, 32'h0, 1'b0, "mid_reset");
    applyStimulus();

    // First edge after reset behaves normally, with bypass
    doWrite(0, 4, 32'hCAFE);
    doRead(1, 4);
    doRead(0, 5);
    expectRead(1, 32'hCAFE, 1'b0, "first_after_reset");
    expectRead(0, 32'h0, 1'b0, "cleared_x5");
    applyStimulus();
    doRead(0, 3);
    doRead(1, 10);
    expectRead(0, 32'h0, 1'b0, "cleared_x3");
    expectRead(1, 32'h0, 1'b0, "cleared_x10");
    applyStimulus();
    doRead(0, 11);
    doRead(1, 12);
    expectRead(0, 32'h0, 1'b0, "cleared_x11");
    expectRead(1, 32'h0, 1'b0, "cleared_x12");
    applyStimulus();
    doRead(0, 7);
    doRead(1, 9);
    expectRead(0, 32'h0, 1'b0, "cleared_x7");
    expectRead(1, 32'h0, 1'b0, "cleared_x9");
    applyStimulus();

    applyStimulus();
    applyStimulus();
    if (sb.size() != 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
